// File: rtl/tile_drain_pkg.sv
// Shared types and helpers for the tile out_c drain stage.
package tile_drain_pkg;

  localparam int unsigned IN_W  = 19;
  localparam int unsigned OUT_W = 8;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             prop;
    logic             last;
  } entry_t;

  // Clamp a signed partial sum into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] sat_c(input logic signed [IN_W-1:0] c);
    logic signed [IN_W-1:0] sat_max;
    logic signed [IN_W-1:0] sat_min;
    sat_max = IN_W'((1 << (OUT_W - 1)) - 1);
    sat_min = IN_W'(-(1 << (OUT_W - 1)));
    if (c > sat_max) begin
      sat_c = sat_max[OUT_W-1:0];
    end else if (c < sat_min) begin
      sat_c = sat_min[OUT_W-1:0];
    end else begin
      sat_c = c[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with a registered head; a push into an empty FIFO becomes
// visible at the head on the following cycle.
module drain_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q;
  logic [AddrW:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
        wr_ptr_q                   <= wr_ptr_q + (AddrW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
      end
    end
  end

  assign head = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/tile_c_drain.sv
// Drains the mesh tile's out_c stream: saturates, tags block boundaries and buffers beats
// behind a ready/valid port, counting beats lost while the buffer is full.
module tile_c_drain #(
  parameter int unsigned IN_W       = tile_drain_pkg::IN_W,
  parameter int unsigned OUT_W      = tile_drain_pkg::OUT_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BLOCK_ROWS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  io_in_c,
  input  logic             io_in_valid,
  input  logic             io_in_propagate,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [OUT_W-1:0] io_out_data,
  output logic             io_out_prop,
  output logic             io_out_last,
  output logic             io_overflow,
  output logic [7:0]       io_drop_count
);

  import tile_drain_pkg::*;

  localparam int unsigned RowW = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

  entry_t          in_entry;
  entry_t          head_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic            blk_last;
  logic [RowW-1:0] row_q;
  logic [RowW-1:0] row_d;
  logic [RowW-1:0] row_eff;
  logic            prev_prop_q;
  logic            overflow_q;
  logic [7:0]      drop_cnt_q;

  assign io_out_valid = !fifo_empty;
  assign pop          = io_out_valid && io_out_ready;
  assign push         = io_in_valid && (!fifo_full || pop);
  assign drop         = io_in_valid && fifo_full && !pop;

  // A propagate flip restarts the block, so the row is forced to 0 before the last test.
  always_comb begin
    row_eff  = (io_in_propagate != prev_prop_q) ? '0 : row_q;
    blk_last = (row_eff == RowW'(BLOCK_ROWS - 1));
    row_d    = row_q;
    if (io_in_valid) begin
      row_d = blk_last ? '0 : row_eff + RowW'(1);
    end
    in_entry.data = sat_c(io_in_c);
    in_entry.prop = io_in_propagate;
    in_entry.last = blk_last;
  end

  // Dropped beats still advance the row counter so alignment follows the tile.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q       <= '0;
      prev_prop_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      row_q <= row_d;
      if (io_in_valid) begin
        prev_prop_q <= io_in_propagate;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  drain_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io_out_data   = head_entry.data;
  assign io_out_prop   = head_entry.prop;
  assign io_out_last   = head_entry.last;
  assign io_overflow   = overflow_q;
  assign io_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_tile_c_drain.sv
// Directed bench for tile_c_drain: saturation, block tagging, overflow and reset behaviour.
module tb_tile_c_drain;

  logic        clock;
  logic        reset;
  logic [18:0] io_in_c;
  logic        io_in_valid;
  logic        io_in_propagate;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_out_data;
  logic        io_out_prop;
  logic        io_out_last;
  logic        io_overflow;
  logic [7:0]  io_drop_count;

  int checks = 0;
  int errors = 0;

  tile_c_drain dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_c         (io_in_c),
    .io_in_valid     (io_in_valid),
    .io_in_propagate (io_in_propagate),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_data     (io_out_data),
    .io_out_prop     (io_out_prop),
    .io_out_last     (io_out_last),
    .io_overflow     (io_overflow),
    .io_drop_count   (io_drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    io_in_valid     = 1'b0;
    io_in_c         = '0;
    io_in_propagate = 1'b0;
    io_out_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int          t1_in  [11] = '{5, 200, -300, -128, 127, 128, -129, 262143, -262144, 0, -1};
  logic [7:0]  t1_exp [11] = '{8'h05, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h80,
                               8'h00, 8'hFF};
  logic [7:0]  sb [$];

  initial begin
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_valid", io_out_valid, 0);
    check("rst_data", io_out_data, 0);
    check("rst_prop", io_out_prop, 0);
    check("rst_last", io_out_last, 0);
    check("rst_overflow", io_overflow, 0);
    check("rst_drop", io_drop_count, 0);
    reset = 1'b0;

    // 1: saturation and one-cycle latency
    io_out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(t1_in[i]);
      tick();
      check("sat_valid", io_out_valid, 1);
      check("sat_data", io_out_data, t1_exp[i]);
    end
    io_in_valid = 1'b0;
    tick();
    check("sat_empty", io_out_valid, 0);

    // 2: 16-beat block with constant propagate
    do_reset();
    io_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(i);
      tick();
      check("blk_last", io_out_last, (i == 15) ? 1 : 0);
    end
    io_in_valid = 1'b0;
    tick();

    // 3: propagate flip on beat 6 restarts the block
    do_reset();
    io_out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      io_in_valid     = 1'b1;
      io_in_propagate = (i >= 5);
      io_in_c         = 19'(i);
      tick();
      check("flip_prop", io_out_prop, (i >= 5) ? 1 : 0);
      check("flip_last", io_out_last, (i == 20) ? 1 : 0);
    end
    io_in_valid = 1'b0;
    tick();

    // 4: overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 6; i++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(10 + i);
      tick();
    end
    io_in_valid = 1'b0;
    check("ovf_flag", io_overflow, 1);
    check("ovf_count", io_drop_count, 2);
    check("ovf_head_stable", io_out_data, 10);
    tick();
    check("ovf_head_stable2", io_out_data, 10);
    io_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_valid", io_out_valid, 1);
      check("ovf_drain_data", io_out_data, 10 + k);
      tick();
    end
    check("ovf_drained", io_out_valid, 0);
    check("ovf_count_kept", io_drop_count, 2);

    // 5: full buffer with simultaneous push and pop never drops
    do_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(20 + i);
      sb.push_back(8'(20 + i));
      tick();
    end
    io_out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(30 + j);
      check("stream_valid", io_out_valid, 1);
      check("stream_data", io_out_data, sb[0]);
      tick();
      void'(sb.pop_front());
      sb.push_back(8'(30 + j));
    end
    io_in_valid = 1'b0;
    check("stream_drop", io_drop_count, 0);
    check("stream_ovf", io_overflow, 0);
    for (int j = 0; j < 4; j++) begin
      check("stream_tail", io_out_data, sb[0]);
      tick();
      void'(sb.pop_front());
    end
    check("stream_empty", io_out_valid, 0);

    // 6: reset with three entries buffered
    do_reset();
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1;
      io_in_c     = 19'(1 + i);
      tick();
    end
    io_in_valid = 1'b0;
    check("pre_rst_valid", io_out_valid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", io_out_valid, 0);
    check("mid_rst_data", io_out_data, 0);
    check("mid_rst_last", io_out_last, 0);
    check("mid_rst_overflow", io_overflow, 0);
    check("mid_rst_drop", io_drop_count, 0);
    reset        = 1'b0;
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_c      = 19'(77);
    tick();
    io_in_valid = 1'b0;
    check("post_rst_valid", io_out_valid, 1);
    check("post_rst_data", io_out_data, 77);
    check("post_rst_last", io_out_last, 0);
    tick();
    check("post_rst_empty", io_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
